dst_pingpong_buf: RTL and testbench

Parametrised ping-pong result buffer that collects per-core results written by word address during the output period and streams completed frames out as an AXI-Stream master with full `tready` backpressure and `tlast` framing. It sits between the core output collection stage and the DMA write channel, and is the successor to the fixed 64×32-bit two-lane destination buffer. Bank ownership is tracked in hardware by explicit commit and free events rather than by an external phase bit, and the writer is throttled when both banks hold unsent frames.

---
 rtl/dst_pingpong_buf.sv | 275 +++++++++++++++++++++++++++
 tb/tb_dst_pingpong_buf.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dst_pingpong_buf.sv
// Ping-pong result buffer: two banks collect per-core results by word address and
// stream each committed frame out as an AXI-Stream master with tlast framing.

module dst_pingpong_buf_chk #(
  parameter int BEAT_W = 64
) (
  input logic              clk,
  input logic              rst,
  input logic              tvalid,
  input logic              tready,
  input logic              tlast,
  input logic [BEAT_W-1:0] tdata,
  input logic [1:0]        frames_pending
);

  a_hold_stable: assert property (@(posedge clk) disable iff (rst)
    (tvalid && !tready) |=> (tvalid && $stable(tdata) && $stable(tlast)));

  a_last_valid: assert property (@(posedge clk) disable iff (rst)
    tlast |-> tvalid);

  a_pending_range: assert property (@(posedge clk) disable iff (rst)
    frames_pending != 2'd3);

endmodule

module dst_pingpong_buf #(
  parameter int DATA_W = 32,
  parameter int LANES  = 2,
  parameter int DEPTH  = 64
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wr_en,
  input  logic [$clog2(DEPTH)-1:0]  wr_addr,
  input  logic [DATA_W-1:0]         wr_data,
  input  logic                      wr_commit,
  output logic                      wr_ready,
  output logic [LANES*DATA_W-1:0]   m_axis_tdata,
  output logic                      m_axis_tvalid,
  input  logic                      m_axis_tready,
  output logic                      m_axis_tlast,
  output logic [1:0]                frames_pending,
  output logic                      wr_err
);

  localparam int AW     = $clog2(DEPTH);
  localparam int LW     = $clog2(LANES);
  localparam int BEATS  = DEPTH / LANES;
  localparam int BW     = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int IW     = $clog2(2 * BEATS);
  localparam int BEAT_W = LANES * DATA_W;

  typedef enum logic [1:0] {
    ST_FREE = 2'd0,
    ST_FULL = 2'd1,
    ST_SEND = 2'd2
  } bank_st_e;

  // Lane-split storage: a write lands in one lane, a read returns a whole beat.
  logic [DATA_W-1:0] r_mem [LANES][2*BEATS];

  bank_st_e          r_bank [2];
  bank_st_e          w_bank_nxt [2];
  logic              r_wp;
  logic              r_rp;
  logic              r_active;
  logic              w_wp_nxt;
  logic              w_rp_nxt;
  logic              w_active_nxt;
  logic              r_wr_ready;
  logic              w_wr_ready_nxt;
  logic [1:0]        r_frames;
  logic              r_wr_err;

  logic [BW-1:0]     r_rd_beat;
  logic              r_issue_done;
  logic [BEAT_W-1:0] r_out_data;
  logic              r_out_last;
  logic              r_out_vld;
  logic [BEAT_W-1:0] r_skid_data;
  logic              r_skid_last;
  logic              r_skid_vld;

  logic              w_wr_acc;
  logic              w_commit_acc;
  logic              w_wr_rej;
  logic              w_start;
  logic              w_pop;
  logic              w_last_hs;
  logic              w_issue;
  logic              w_issue_last;
  logic [AW-1:0]     w_lane_mask;
  logic [BW-1:0]     w_wr_row;
  logic [IW-1:0]     w_wr_idx;
  logic [IW-1:0]     w_rd_idx;
  logic [BEAT_W-1:0] w_rd_beat;

  function automatic logic [IW-1:0] bank_idx(input logic bank, input logic [BW-1:0] row);
    bank_idx = bank ? (IW'(BEATS) + IW'(row)) : IW'(row);
  endfunction

  assign w_lane_mask = AW'(LANES - 1);
  assign w_wr_row    = BW'(wr_addr >> LW);
  assign w_wr_idx    = bank_idx(r_wp, w_wr_row);
  assign w_rd_idx    = bank_idx(r_rp, r_rd_beat);

  // Control strobes derived from the registered bank state and the inputs.
  always_comb begin
    w_wr_acc     = wr_en & r_wr_ready;
    w_commit_acc = wr_commit & r_wr_ready;
    w_wr_rej     = (wr_en | wr_commit) & ~r_wr_ready;
    w_start      = ~r_active & (r_bank[r_rp] == ST_FULL);
    w_pop        = r_out_vld & m_axis_tready;
    w_last_hs    = w_pop & r_out_last;
    // Room exists when the skid slot is empty or the head leaves this cycle.
    w_issue      = r_active & ~r_issue_done & (~r_skid_vld | w_pop);
    w_issue_last = (r_rd_beat == BW'(BEATS - 1));
  end

  // Bank ownership next state: commit fills the write bank, the read side claims and frees.
  always_comb begin
    w_bank_nxt[0] = r_bank[0];
    w_bank_nxt[1] = r_bank[1];
    w_rp_nxt      = r_rp;
    w_active_nxt  = r_active;
    if (w_commit_acc) begin
      w_bank_nxt[r_wp] = ST_FULL;
      w_wp_nxt         = ~r_wp;
    end else begin
      w_wp_nxt = r_wp;
    end
    if (w_start) begin
      w_bank_nxt[r_rp] = ST_SEND;
      w_active_nxt     = 1'b1;
    end else if (w_last_hs) begin
      w_bank_nxt[r_rp] = ST_FREE;
      w_rp_nxt         = ~r_rp;
      w_active_nxt     = 1'b0;
    end else begin
      w_active_nxt = r_active;
    end
    w_wr_ready_nxt = (w_bank_nxt[w_wp_nxt] == ST_FREE);
  end

  // Bank state, pointers and the registered writer handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bank[0]  <= ST_FREE;
      r_bank[1]  <= ST_FREE;
      r_wp       <= 1'b0;
      r_rp       <= 1'b0;
      r_active   <= 1'b0;
      r_wr_ready <= 1'b1;
    end else begin
      r_bank[0]  <= w_bank_nxt[0];
      r_bank[1]  <= w_bank_nxt[1];
      r_wp       <= w_wp_nxt;
      r_rp       <= w_rp_nxt;
      r_active   <= w_active_nxt;
      r_wr_ready <= w_wr_ready_nxt;
    end
  end

  // Pending-frame count and sticky protocol error flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_frames <= 2'd0;
      r_wr_err <= 1'b0;
    end else begin
      case ({w_commit_acc, w_last_hs})
        2'b10:   r_frames <= r_frames + 2'd1;
        2'b01:   r_frames <= r_frames - 2'd1;
        default: r_frames <= r_frames;
      endcase
      r_wr_err <= r_wr_err | w_wr_rej;
    end
  end

  // RAM write port; contents survive reset.
  always_ff @(posedge clk) begin
    for (int j = 0; j < LANES; j++) begin
      if (w_wr_acc && ((wr_addr & w_lane_mask) == AW'(j))) begin
        r_mem[j][w_wr_idx] <= wr_data;
      end
    end
  end

  // Beat-wide read of the current read row across all lanes.
  always_comb begin
    w_rd_beat = '0;
    for (int j = 0; j < LANES; j++) begin
      w_rd_beat[j*DATA_W +: DATA_W] = r_mem[j][w_rd_idx];
    end
  end

  // Beat issue counter and the two-entry output buffer (head drives the stream).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_beat    <= '0;
      r_issue_done <= 1'b0;
      r_out_data   <= '0;
      r_out_last   <= 1'b0;
      r_out_vld    <= 1'b0;
      r_skid_data  <= '0;
      r_skid_last  <= 1'b0;
      r_skid_vld   <= 1'b0;
    end else begin
      if (w_start) begin
        r_rd_beat    <= '0;
        r_issue_done <= 1'b0;
      end else if (w_issue) begin
        r_rd_beat    <= r_rd_beat + BW'(1);
        r_issue_done <= w_issue_last;
      end else begin
        r_rd_beat    <= r_rd_beat;
        r_issue_done <= r_issue_done;
      end

      case ({w_issue, w_pop})
        2'b11: begin
          if (r_skid_vld) begin
            r_out_data  <= r_skid_data;
            r_out_last  <= r_skid_last;
            r_skid_data <= w_rd_beat;
            r_skid_last <= w_issue_last;
          end else begin
            r_out_data <= w_rd_beat;
            r_out_last <= w_issue_last;
          end
        end
        2'b10: begin
          if (r_out_vld) begin
            r_skid_data <= w_rd_beat;
            r_skid_last <= w_issue_last;
            r_skid_vld  <= 1'b1;
          end else begin
            r_out_data <= w_rd_beat;
            r_out_last <= w_issue_last;
            r_out_vld  <= 1'b1;
          end
        end
        2'b01: begin
          r_out_data <= r_skid_data;
          r_out_last <= r_skid_last & r_skid_vld;
          r_out_vld  <= r_skid_vld;
          r_skid_vld <= 1'b0;
        end
        default: begin
          r_out_vld <= r_out_vld;
        end
      endcase
    end
  end

  assign wr_ready       = r_wr_ready;
  assign m_axis_tdata   = r_out_data;
  assign m_axis_tvalid  = r_out_vld;
  assign m_axis_tlast   = r_out_last;
  assign frames_pending = r_frames;
  assign wr_err         = r_wr_err;

  dst_pingpong_buf_chk #(
    .BEAT_W(BEAT_W)
  ) u_chk (
    .clk            (clk),
    .rst            (rst),
    .tvalid         (m_axis_tvalid),
    .tready         (m_axis_tready),
    .tlast          (m_axis_tlast),
    .tdata          (m_axis_tdata),
    .frames_pending (frames_pending)
  );

endmodule

// File: tb/tb_dst_pingpong_buf.sv
// Self-checking bench for dst_pingpong_buf: scoreboard of expected beats, one task per scenario.
`timescale 1ns/1ps
module tb_dst_pingpong_buf;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        wr_en0, wr_commit0, wr_ready0, tvalid0, tready0, tlast0, wr_err0;
  logic [5:0]  wr_addr0;
  logic [31:0] wr_data0;
  logic [63:0] tdata0;
  logic [1:0]  fp0;

  logic        wr_en1, wr_commit1, wr_ready1, tvalid1, tready1, tlast1, wr_err1;
  logic [4:0]  wr_addr1;
  logic [15:0] wr_data1;
  logic [63:0] tdata1;
  logic [1:0]  fp1;

  dst_pingpong_buf u_dut0 (
    .clk(clk), .rst(rst), .wr_en(wr_en0), .wr_addr(wr_addr0), .wr_data(wr_data0),
    .wr_commit(wr_commit0), .wr_ready(wr_ready0), .m_axis_tdata(tdata0),
    .m_axis_tvalid(tvalid0), .m_axis_tready(tready0), .m_axis_tlast(tlast0),
    .frames_pending(fp0), .wr_err(wr_err0)
  );

  dst_pingpong_buf #(.DATA_W(16), .LANES(4), .DEPTH(32)) u_dut1 (
    .clk(clk), .rst(rst), .wr_en(wr_en1), .wr_addr(wr_addr1), .wr_data(wr_data1),
    .wr_commit(wr_commit1), .wr_ready(wr_ready1), .m_axis_tdata(tdata1),
    .m_axis_tvalid(tvalid1), .m_axis_tready(tready1), .m_axis_tlast(tlast1),
    .frames_pending(fp1), .wr_err(wr_err1)
  );

  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  logic [64:0] sb0 [$];
  logic [31:0] model0 [64];
  int          beats0   = 0;
  int          frames0  = 0;
  int          hs_cyc   = 0;
  int          rise_cyc = 0;
  logic        prev_stall = 1'b0;
  logic        prev_valid = 1'b0;
  logic [63:0] prev_data;
  logic        prev_last;
  logic [64:0] mon_exp;

  always @(posedge clk) cyc++;

  // Output monitor for the default instance: stall stability and scoreboard pop on handshake.
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
      prev_valid = 1'b0;
    end else begin
      if (prev_stall) begin
        n_tests++;
        if (tvalid0 !== 1'b1 || tdata0 !== prev_data || tlast0 !== prev_last) begin
          n_fail++;
          $display("FAIL stall_hold: got v=%0b last=%0b data=%h, need v=1 last=%0b data=%h",
                   tvalid0, tlast0, tdata0, prev_last, prev_data);
        end
      end
      if (tvalid0 === 1'b1 && !prev_valid) rise_cyc = cyc;
      if (tvalid0 === 1'b1 && tready0 === 1'b1) begin
        n_tests++;
        if (sb0.size() == 0) begin
          n_fail++;
          $display("FAIL beat_extra: got beat last=%0b data=%h, need no beat", tlast0, tdata0);
        end else begin
          mon_exp = sb0.pop_front();
          if ({tlast0, tdata0} !== mon_exp) begin
            n_fail++;
            $display("FAIL beat_data: got last=%0b data=%h, need last=%0b data=%h",
                     tlast0, tdata0, mon_exp[64], mon_exp[63:0]);
          end
        end
        beats0++;
        if (tlast0) begin
          frames0++;
          hs_cyc = cyc + 1;
        end
      end
      prev_stall = tvalid0 & ~tready0;
      prev_valid = tvalid0;
      prev_data  = tdata0;
      prev_last  = tlast0;
    end
  end

  task automatic wr0(input int a, input logic [31:0] d);
    wr_en0   = 1'b1;
    wr_addr0 = 6'(a);
    wr_data0 = d;
    model0[a] = d;
    @(posedge clk); #1;
    wr_en0 = 1'b0;
  endtask

  task automatic commit0();
    for (int k = 0; k < 32; k++) sb0.push_back({(k == 31), model0[2*k+1], model0[2*k]});
    wr_commit0 = 1'b1;
    @(posedge clk); #1;
    wr_commit0 = 1'b0;
  endtask

  task automatic wait_frames0(input int target, input bit rnd, output bit ok);
    int n;
    n = 0;
    while (frames0 < target && n < 3000) begin
      if (rnd) tready0 = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      n++;
    end
    ok = (frames0 >= target);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_tests++; if (tvalid0 !== 1'b0) begin n_fail++; $display("FAIL rst_tvalid: got %0b need 0", tvalid0); end
    n_tests++; if (tlast0 !== 1'b0) begin n_fail++; $display("FAIL rst_tlast: got %0b need 0", tlast0); end
    n_tests++; if (tdata0 !== 64'h0) begin n_fail++; $display("FAIL rst_tdata: got %h need 0", tdata0); end
    n_tests++; if (fp0 !== 2'd0) begin n_fail++; $display("FAIL rst_pending: got %0d need 0", fp0); end
    n_tests++; if (wr_err0 !== 1'b0) begin n_fail++; $display("FAIL rst_wr_err: got %0b need 0", wr_err0); end
    n_tests++; if (wr_ready0 !== 1'b1) begin n_fail++; $display("FAIL rst_wr_ready: got %0b need 1", wr_ready0); end
    n_tests++; if (tvalid1 !== 1'b0 || wr_ready1 !== 1'b1) begin
      n_fail++; $display("FAIL rst_var: got v=%0b rdy=%0b need v=0 rdy=1", tvalid1, wr_ready1);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    int b0, f0;
    bit ok;
    tready0 = 1'b1;
    for (int i = 0; i < 64; i++) wr0(i, 32'h100 + 32'(i));
    b0 = beats0; f0 = frames0;
    commit0();
    n_tests++; if (tvalid0 !== 1'b0) begin n_fail++; $display("FAIL lat_n0: got tvalid %0b need 0", tvalid0); end
    n_tests++; if (fp0 !== 2'd1) begin n_fail++; $display("FAIL single_pending1: got %0d need 1", fp0); end
    @(posedge clk); #1;
    n_tests++; if (tvalid0 !== 1'b0) begin n_fail++; $display("FAIL lat_n1: got tvalid %0b need 0", tvalid0); end
    @(posedge clk); #1;
    n_tests++; if (tvalid0 !== 1'b1) begin n_fail++; $display("FAIL lat_n2: got tvalid %0b need 1", tvalid0); end
    wait_frames0(f0 + 1, 1'b0, ok);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL single_timeout: got %0d frames need %0d", frames0, f0 + 1); end
    n_tests++; if (fp0 !== 2'd0) begin n_fail++; $display("FAIL single_pending0: got %0d need 0", fp0); end
    n_tests++; if (beats0 - b0 != 32) begin n_fail++; $display("FAIL single_beats: got %0d need 32", beats0 - b0); end
    n_tests++; if (hs_cyc - rise_cyc != 32) begin
      n_fail++; $display("FAIL single_rate: got %0d cycles need 32", hs_cyc - rise_cyc);
    end
  endtask

  task automatic test_backpressure();
    int b0, f0;
    bit ok;
    tready0 = 1'b0;
    for (int i = 0; i < 64; i++) wr0(i, 32'h100 + 32'(i));
    b0 = beats0; f0 = frames0;
    commit0();
    wait_frames0(f0 + 1, 1'b1, ok);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL bp_timeout: got %0d frames need %0d", frames0, f0 + 1); end
    n_tests++; if (beats0 - b0 != 32) begin n_fail++; $display("FAIL bp_beats: got %0d need 32", beats0 - b0); end
    n_tests++; if (sb0.size() != 0) begin n_fail++; $display("FAIL bp_left: got %0d left need 0", sb0.size()); end
  endtask

  task automatic test_both_full();
    int f0, a_hs, gap;
    bit ok;
    tready0 = 1'b0;
    f0 = frames0;
    for (int i = 0; i < 64; i++) wr0(i, 32'hA00 + 32'(i));
    commit0();
    n_tests++; if (wr_ready0 !== 1'b1) begin n_fail++; $display("FAIL bf_ready_one: got %0b need 1", wr_ready0); end
    for (int i = 0; i < 64; i++) wr0(i, 32'hB00 + 32'(i));
    commit0();
    n_tests++; if (wr_ready0 !== 1'b0) begin n_fail++; $display("FAIL bf_ready_two: got %0b need 0", wr_ready0); end
    n_tests++; if (fp0 !== 2'd2) begin n_fail++; $display("FAIL bf_pending2: got %0d need 2", fp0); end
    n_tests++; if (wr_err0 !== 1'b0) begin n_fail++; $display("FAIL bf_err_early: got %0b need 0", wr_err0); end
    wr_en0 = 1'b1; wr_addr0 = 6'd0; wr_data0 = 32'hDEAD;
    @(posedge clk); #1;
    wr_en0 = 1'b0;
    n_tests++; if (wr_err0 !== 1'b1) begin n_fail++; $display("FAIL bf_err_set: got %0b need 1", wr_err0); end
    n_tests++; if (fp0 !== 2'd2 || wr_ready0 !== 1'b0) begin
      n_fail++; $display("FAIL bf_drop: got pending=%0d rdy=%0b need 2/0", fp0, wr_ready0);
    end
    repeat (3) @(posedge clk);
    #1;
    tready0 = 1'b1;
    wait_frames0(f0 + 1, 1'b0, ok);
    a_hs = hs_cyc;
    n_tests++; if (!ok) begin n_fail++; $display("FAIL bf_a_timeout: got %0d frames need %0d", frames0, f0 + 1); end
    n_tests++; if (wr_ready0 !== 1'b1) begin n_fail++; $display("FAIL bf_ready_after_a: got %0b need 1", wr_ready0); end
    wait_frames0(f0 + 2, 1'b0, ok);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL bf_b_timeout: got %0d frames need %0d", frames0, f0 + 2); end
    gap = rise_cyc - a_hs;
    n_tests++; if (gap < 1 || gap > 2) begin n_fail++; $display("FAIL bf_gap: got %0d cycles need 1..2", gap); end
    n_tests++; if (fp0 !== 2'd0 || sb0.size() != 0) begin
      n_fail++; $display("FAIL bf_end: got pending=%0d left=%0d need 0/0", fp0, sb0.size());
    end
  endtask

  task automatic test_reorder();
    int b0, f0;
    bit ok;
    tready0 = 1'b1;
    for (int i = 63; i >= 0; i--) wr0(i, 32'h100 + 32'(i));
    wr0(5, 32'h555);
    b0 = beats0; f0 = frames0;
    commit0();
    wait_frames0(f0 + 1, 1'b0, ok);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL ooo_timeout: got %0d frames need %0d", frames0, f0 + 1); end
    n_tests++; if (beats0 - b0 != 32 || sb0.size() != 0) begin
      n_fail++; $display("FAIL ooo_beats: got %0d beats left=%0d need 32/0", beats0 - b0, sb0.size());
    end
  endtask

  task automatic test_mid_reset();
    int b0, f0, n;
    bit ok;
    tready0 = 1'b1;
    for (int i = 0; i < 64; i++) wr0(i, 32'h300 + 32'(i));
    commit0();
    b0 = beats0; n = 0;
    while (beats0 - b0 < 10 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    n_tests++; if (beats0 - b0 != 10) begin n_fail++; $display("FAIL mr_beats10: got %0d need 10", beats0 - b0); end
    rst = 1'b1;
    #1;
    n_tests++; if (tvalid0 !== 1'b0) begin n_fail++; $display("FAIL mr_tvalid: got %0b need 0", tvalid0); end
    n_tests++; if (fp0 !== 2'd0) begin n_fail++; $display("FAIL mr_pending: got %0d need 0", fp0); end
    n_tests++; if (wr_ready0 !== 1'b1) begin n_fail++; $display("FAIL mr_wr_ready: got %0b need 1", wr_ready0); end
    n_tests++; if (wr_err0 !== 1'b0) begin n_fail++; $display("FAIL mr_wr_err: got %0b need 0", wr_err0); end
    sb0.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_tests++; if (tvalid0 !== 1'b0) begin n_fail++; $display("FAIL mr_abandon: got tvalid %0b need 0", tvalid0); end
    for (int i = 0; i < 64; i++) wr0(i, 32'h700 + 32'(i));
    b0 = beats0; f0 = frames0;
    commit0();
    wait_frames0(f0 + 1, 1'b0, ok);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL mr_timeout: got %0d frames need %0d", frames0, f0 + 1); end
    n_tests++; if (beats0 - b0 != 32 || sb0.size() != 0) begin
      n_fail++; $display("FAIL mr_new_frame: got %0d beats left=%0d need 32/0", beats0 - b0, sb0.size());
    end
  endtask

  task automatic test_param();
    logic [64:0] sb1 [$];
    logic [64:0] exp_b;
    int n, got;
    tready1 = 1'b1;
    for (int i = 0; i < 32; i++) begin
      wr_en1 = 1'b1; wr_addr1 = 5'(i); wr_data1 = 16'(i);
      @(posedge clk); #1;
      wr_en1 = 1'b0;
    end
    for (int k = 0; k < 8; k++) sb1.push_back({(k == 7), 16'(4*k+3), 16'(4*k+2), 16'(4*k+1), 16'(4*k)});
    wr_commit1 = 1'b1;
    @(posedge clk); #1;
    wr_commit1 = 1'b0;
    n = 0; got = 0;
    while (got < 8 && n < 100) begin
      if (tvalid1 === 1'b1) begin
        exp_b = sb1.pop_front();
        n_tests++;
        if ({tlast1, tdata1} !== exp_b) begin
          n_fail++; $display("FAIL var_beat%0d: got last=%0b data=%h need last=%0b data=%h",
                             got, tlast1, tdata1, exp_b[64], exp_b[63:0]);
        end
        if (got == 0) begin
          n_tests++;
          if (tdata1 !== 64'h0003_0002_0001_0000) begin
            n_fail++; $display("FAIL var_beat0_const: got %h need 0003000200010000", tdata1);
          end
        end
        got++;
      end
      @(posedge clk); #1;
      n++;
    end
    n_tests++; if (got != 8) begin n_fail++; $display("FAIL var_count: got %0d beats need 8", got); end
    n_tests++; if (tvalid1 !== 1'b0 || fp1 !== 2'd0) begin
      n_fail++; $display("FAIL var_end: got v=%0b pending=%0d need 0/0", tvalid1, fp1);
    end
  endtask

  initial begin
    rst = 1'b1;
    wr_en0 = 1'b0; wr_commit0 = 1'b0; wr_addr0 = 6'd0; wr_data0 = 32'd0; tready0 = 1'b0;
    wr_en1 = 1'b0; wr_commit1 = 1'b0; wr_addr1 = 5'd0; wr_data1 = 16'd0; tready1 = 1'b0;
    test_reset();
    test_single();
    test_backpressure();
    test_both_full();
    test_reorder();
    test_mid_reset();
    test_param();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
